// File: rtl/led_matrix_scan_pkg.sv
// Shared flappy-bird display definitions: default field size, FSM encodings
// and the bitmap indexing convention used by the action and display stages.
package led_matrix_scan_pkg;

    localparam int GS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        SEQ_INPUT   = 2'd0,
        SEQ_ACTION  = 2'd1,
        SEQ_DISPLAY = 2'd2
    } seq_state_t;

    // Pixel (row r, column c) lives at bit r*GS+c of the field bitmap.
    function automatic int pix_idx(input int r, input int c, input int gs);
        return r * gs + c;
    endfunction

endpackage

// File: rtl/led_matrix_scan_dwell_timer.sv
// Per-row dwell counter. zero_o reports that the count loaded at the next
// edge is zero (blank slot); wrap_o pulses on the last count of a row.
module scan_dwell_timer #(
    parameter int DWELL_W = 14
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic zero_o,
    output logic wrap_o
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign wrap_o = en_i && (&cnt_q);
    assign zero_o = clr_i || wrap_o || (!en_i && (cnt_q == '0));

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for the LED matrix: snapshots the field, scans it
// for FRAMES passes with a blank anti-ghosting slot per row, then pulses done.
module led_matrix_scan
    import led_matrix_scan_pkg::*;
#(
    parameter int GS      = GS_DEF,
    parameter int DWELL_W = 14,
    parameter int FRAMES  = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             e_disp_i,
    input  logic [GS*GS-1:0] matrix_i,
    output logic [GS-1:0]    col_val_o,
    output logic [GS-1:0]    row_val_o,
    output logic             d_disp_o
);

    localparam int ROW_W = (GS > 1) ? $clog2(GS) : 1;
    localparam int FRM_W = $clog2(FRAMES) + 1;

    scan_state_t        state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic [GS*GS-1:0]   snap_q, snap_d;
    logic [GS-1:0]      row_oh_d, col_d;
    logic               done_d;
    logic               lit_d;
    logic               dwell_clr, dwell_en, dwell_zero, dwell_wrap;

    assign dwell_clr = (state_q == ST_IDLE) && e_disp_i;
    assign dwell_en  = (state_q == ST_SCAN);

    scan_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (dwell_clr),
        .en_i    (dwell_en),
        .zero_o  (dwell_zero),
        .wrap_o  (dwell_wrap)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        frame_d = frame_q;
        snap_d  = snap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (e_disp_i) begin
                    state_d = ST_SCAN;
                    row_d   = '0;
                    frame_d = '0;
                    snap_d  = matrix_i;
                end
            end
            ST_SCAN: begin
                if (!e_disp_i) begin
                    state_d = ST_IDLE;
                end else if (dwell_wrap) begin
                    if (row_q == ROW_W'(GS - 1)) begin
                        row_d   = '0;
                        frame_d = frame_q + 1'b1;
                        if (frame_q == FRM_W'(FRAMES - 1)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!e_disp_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-cycle slot so they line up with it.
    always_comb begin
        lit_d    = (state_d == ST_SCAN) && !dwell_zero;
        done_d   = (state_d == ST_DONE);
        row_oh_d = '0;
        col_d    = '0;
        if (lit_d) begin
            row_oh_d[row_d] = 1'b1;
            col_d           = snap_d[pix_idx(int'(row_d), 0, GS) +: GS];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            frame_q   <= '0;
            snap_q    <= '0;
            row_val_o <= '0;
            col_val_o <= '0;
            d_disp_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            snap_q    <= snap_d;
            row_val_o <= row_oh_d;
            col_val_o <= col_d;
            d_disp_o  <= done_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed-sequence bench for led_matrix_scan with random field bitmaps,
// checked cycle by cycle against a slot-arithmetic reference model.
module tb_led_matrix_scan;

    localparam int GS       = 8;
    localparam int DWELL_W  = 2;
    localparam int FRAMES   = 2;
    localparam int DWELL    = 1 << DWELL_W;
    localparam int SCAN_CYC = FRAMES * GS * DWELL;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             e_disp_i;
    logic [GS*GS-1:0] matrix_i;
    logic [GS-1:0]    col_val_o;
    logic [GS-1:0]    row_val_o;
    logic             d_disp_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .GS      (GS),
        .DWELL_W (DWELL_W),
        .FRAMES  (FRAMES)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .e_disp_i  (e_disp_i),
        .matrix_i  (matrix_i),
        .col_val_o (col_val_o),
        .row_val_o (row_val_o),
        .d_disp_o  (d_disp_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k = cycles since the enable was sampled (0 or out of range means idle).
    task automatic check_cycle(input int k, input logic [GS*GS-1:0] snap, input string tag);
        logic [GS-1:0] er, ec;
        logic          ed;
        int            slot, d, r;
        er = '0;
        ec = '0;
        ed = 1'b0;
        if (k >= 1 && k <= SCAN_CYC) begin
            slot = k - 1;
            d    = slot % DWELL;
            r    = (slot / DWELL) % GS;
            if (d != 0) begin
                er = GS'(1 << r);
                ec = snap[r*GS +: GS];
            end
        end else if (k == SCAN_CYC + 1) begin
            ed = 1'b1;
        end
        checks++;
        assert (row_val_o === er) else begin
            errors++;
            $error("FAIL %s row k=%0d observed %h expected %h", tag, k, row_val_o, er);
        end
        checks++;
        assert (col_val_o === ec) else begin
            errors++;
            $error("FAIL %s col k=%0d observed %h expected %h", tag, k, col_val_o, ec);
        end
        checks++;
        assert (d_disp_o === ed) else begin
            errors++;
            $error("FAIL %s done k=%0d observed %b expected %b", tag, k, d_disp_o, ed);
        end
    endtask

    task automatic run_scan(input logic [GS*GS-1:0] snap, input int last_k,
                            input int change_k, input logic [GS*GS-1:0] new_m,
                            input string tag);
        for (int k = 1; k <= last_k; k++) begin
            tick();
            check_cycle(k, snap, tag);
            if (k == change_k) matrix_i = new_m;
        end
    endtask

    initial begin
        logic [GS*GS-1:0] m;
        logic [GS*GS-1:0] m2;

        // Reset held with enable high and all-ones field: nothing may scan.
        reset_i  = 1'b1;
        e_disp_i = 1'b1;
        matrix_i = '1;
        repeat (3) begin
            tick();
            check_cycle(0, '0, "reset");
        end

        // Checkerboard scan; field zeroed at cycle 10, enable held past done.
        reset_i  = 1'b0;
        m        = 64'hAA55AA55AA55AA55;
        matrix_i = m;
        run_scan(m, SCAN_CYC + 16, 10, '0, "checker");

        e_disp_i = 1'b0;
        tick();
        check_cycle(0, '0, "drop_en");
        tick();
        check_cycle(0, '0, "idle");

        // Re-enable with a random field.
        m        = {$urandom, $urandom};
        matrix_i = m;
        e_disp_i = 1'b1;
        run_scan(m, SCAN_CYC + 3, 5, {$urandom, $urandom}, "rand_scan");
        e_disp_i = 1'b0;
        tick();
        check_cycle(0, '0, "rand_drop");
        tick();
        check_cycle(0, '0, "rand_idle");

        // Abort at cycle 20: outputs blank from cycle 21 and no done pulse.
        m        = {$urandom, $urandom};
        matrix_i = m;
        e_disp_i = 1'b1;
        run_scan(m, 20, 0, '0, "pre_abort");
        e_disp_i = 1'b0;
        for (int k = 21; k <= SCAN_CYC + 10; k++) begin
            tick();
            check_cycle(0, '0, "abort");
        end

        // Mid-scan reset at cycle 30, then a fresh scan from row 0, frame 0.
        m        = {$urandom, $urandom};
        matrix_i = m;
        e_disp_i = 1'b1;
        run_scan(m, 30, 0, '0, "pre_reset");
        reset_i = 1'b1;
        tick();
        check_cycle(0, '0, "mid_reset");
        m2       = {$urandom, $urandom};
        matrix_i = m2;
        reset_i  = 1'b0;
        run_scan(m2, SCAN_CYC + 4, 0, '0, "post_reset");
        e_disp_i = 1'b0;
        tick();
        check_cycle(0, '0, "final_drop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
